bitop_sequencer: RTL
====================

// Module: bitop_sequencer
// PURPOSE
//  Multi-cycle controller for the 8-bit bit-manipulation datapath (set/clear bit, single-step shift/rotate).
//  Accepts one operation per start handshake and iterates the 1-bit shift/rotate step AMOUNT times.
//  Registers the result and owns the architectural zero/carry/overflow flag register.
//  Sits between instruction decode (requester) and the register file (result consumer).
// PARAMETERS
//  WIDTH   8   operand/result width in bits
//  AMT_W   4   width of shift amount and bit-position fields
// PORTS
//  clk            in   1      rising-edge clock
//  reset          in   1      reset, synchronous, active-high
//  start_valid    in   1      request present
//  start_ready    out  1      sequencer can accept (high only in IDLE)
//  op             in   3      0 SET, 1 CLR, 2 SHL, 3 SHR, 4 ROL, 5 ROR, 6-7 illegal
//  operand        in   WIDTH  input register value
//  amount         in   AMT_W  bit position (SET/CLR) or step count (shift/rotate)
//  abort          in   1      cancel in-flight op, return to IDLE
//  done_valid     out  1      result available
//  done_ready     in   1      consumer takes result
//  result         out  WIDTH  operation result (valid while done_valid)
//  err            out  1      illegal op or position >= WIDTH (valid while done_valid)
//  zero_flag      out  1      architectural Z flag
//  carry_flag     out  1      architectural C flag
//  overflow_flag  out  1      architectural V flag
// BEHAVIOUR
//  - Reset: state IDLE; result, err, done_valid, all flags = 0; start_ready = 1 next cycle.
//  - FSM IDLE -> RUN -> DONE -> IDLE. Accept when start_valid & start_ready (cycle T); op, operand, amount latched at T.
//  - SET/CLR, illegal op, or amount==0: RUN skipped, DONE at T+1.
//  - SET/CLR: result = operand | (1<<pos), resp. & ~(1<<pos); C=0, V=0.
//  - SET/CLR with pos >= WIDTH: result = operand unchanged, err=1.
//  - Illegal op: result = operand, err=1, flags NOT updated.
//  - Shift/rotate, amount k>=1: RUN at T+1..T+k, one 1-bit step per cycle; DONE at T+k+1.
//  - Shift/rotate step, SHL/ROL: carry = bit WIDTH-1 of current value; ROL feeds it back into bit 0.
//  - Shift/rotate step, SHR/ROR: carry = bit 0 of current value; ROR feeds it back into bit WIDTH-1.
//  - Shift/rotate step, fill: SHL/SHR fill with 0.
//  - k > WIDTH is legal; steps still run (SHL/SHR yield 0, rotates wrap modulo WIDTH).
//  - C = bit shifted out by the last step (0 when k==0).
//  - V = 1 only for SHL if MSB changed on any step; else 0.
//  - Z = (result == 0) for all legal ops.
//  - Flags update once, on the edge entering DONE (legal ops only); held otherwise.
//  - DONE: done_valid=1, result/err stable until done_ready; IDLE next cycle.
//  - Back-to-back: minimum one IDLE cycle between ops.
//  - Backpressure: done_ready low holds DONE indefinitely; no new op accepted.
//  - abort in RUN or DONE: next state IDLE, done_valid=0, flags unchanged; abort in IDLE ignored.
//  - abort at same edge as RUN->DONE: abort wins, flags unchanged.
//  - reset overrides abort and all handshakes in any state.
// TESTING
//  - SET, operand 0x00, amount 3 at T -> done_valid at T+1, result 0x08, Z=0 C=0 V=0, err=0.
//  - CLR, operand 0xFF, amount 9 -> result 0xFF, err=1; flags Z/C/V = 0/0/0, V=0.
//  - SHL, 0x81 by 1 -> result 0x02, C=1, V=1, Z=0, DONE at T+2.
//  - ROR, 0x01 by 3 -> result 0x20, C=0, DONE at T+4.
//  - SHR, 0x01 by 1 -> result 0x00, Z=1, C=1.
//  - done_ready held low 5 cycles -> result stable, start_ready=0 throughout.
//  - reset asserted mid-RUN -> IDLE, flags 0, next op runs correctly.
//  - abort at step 2 of ROL 0x80 by 4 -> IDLE, no done_valid, flags retain prior values.

Source files
------------

// File: rtl/bitop_sequencer_if.sv
// bitop_sequencer_if: request/response bus between decode, bit-op sequencer and register file
interface bitop_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
);
  logic             start_valid;
  logic             start_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] operand;
  logic [AMT_W-1:0] amount;
  logic             abort;
  logic             done_valid;
  logic             done_ready;
  logic [WIDTH-1:0] result;
  logic             err;
  logic             zero_flag;
  logic             carry_flag;
  logic             overflow_flag;
  modport master (
    output start_valid, op, operand, amount, abort, done_ready,
    input  start_ready, done_valid, result, err, zero_flag, carry_flag, overflow_flag
  );
  modport slave (
    input  start_valid, op, operand, amount, abort, done_ready,
    output start_ready, done_valid, result, err, zero_flag, carry_flag, overflow_flag
  );
endinterface

// File: rtl/bitop_sequencer.sv
// bitop_sequencer: multi-cycle set/clear/shift/rotate controller owning the Z/C/V flag register
module bitop_sequencer #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input logic            clk,
  input logic            reset,
  bitop_sequencer_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  localparam logic [2:0] OP_SET = 3'd0, OP_CLR = 3'd1, OP_SHL = 3'd2, OP_SHR = 3'd3, OP_ROL = 3'd4, OP_ROR = 3'd5;
  logic [1:0]       state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic             v_q, v_d;
  logic             err_q, err_d;
  logic             zf_q, zf_d, cf_q, cf_d, vf_q, vf_d;
  logic             left, out_bit, ovf_step;
  logic [WIDTH-1:0] shifted, mask, imm_res;
  logic             bit_op, illegal, pos_ok, runs, imm_err;
  always_comb begin
    left     = op_q == OP_SHL || op_q == OP_ROL;
    out_bit  = left ? res_q[WIDTH-1] : res_q[0];
    shifted  = left ? {res_q[WIDTH-2:0], (op_q == OP_ROL) & out_bit}
                    : {(op_q == OP_ROR) & out_bit, res_q[WIDTH-1:1]};
    ovf_step = op_q == OP_SHL && shifted[WIDTH-1] != res_q[WIDTH-1];
  end
  always_comb begin
    bit_op  = bus.op == OP_SET || bus.op == OP_CLR;
    illegal = bus.op > OP_ROR;
    pos_ok  = 32'(bus.amount) < WIDTH;
    mask    = WIDTH'(1) << bus.amount;
    runs    = !bit_op && !illegal && bus.amount != '0;
    imm_res = (bit_op && pos_ok) ? (bus.op == OP_SET ? bus.operand | mask : bus.operand & ~mask) : bus.operand;
    imm_err = illegal || (bit_op && !pos_ok);
  end
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    v_d     = v_q;
    err_d   = err_q;
    zf_d    = zf_q;
    cf_d    = cf_q;
    vf_d    = vf_q;
    if (state_q == IDLE) begin
      if (bus.start_valid) begin
        op_d    = bus.op;
        res_d   = imm_res;
        err_d   = imm_err;
        cnt_d   = bus.amount;
        v_d     = 1'b0;
        state_d = runs ? RUN : DONE;
        // Single-cycle ops commit flags now; illegal ops leave them untouched
        if (!runs && !illegal) begin
          zf_d = imm_res == '0;
          cf_d = 1'b0;
          vf_d = 1'b0;
        end
      end
    end else if (state_q == RUN) begin
      if (bus.abort) begin
        state_d = IDLE;
      end else begin
        res_d = shifted;
        v_d   = v_q | ovf_step;
        cnt_d = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) begin
          state_d = DONE;
          zf_d    = shifted == '0;
          cf_d    = out_bit;
          vf_d    = v_q | ovf_step;
        end
      end
    end else if (state_q == DONE) begin
      state_d = (bus.abort || bus.done_ready) ? IDLE : DONE;
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      v_q     <= 1'b0;
      err_q   <= 1'b0;
      zf_q    <= 1'b0;
      cf_q    <= 1'b0;
      vf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      v_q     <= v_d;
      err_q   <= err_d;
      zf_q    <= zf_d;
      cf_q    <= cf_d;
      vf_q    <= vf_d;
    end
  end
  assign bus.start_ready   = state_q == IDLE;
  assign bus.done_valid    = state_q == DONE;
  assign bus.result        = res_q;
  assign bus.err           = err_q;
  assign bus.zero_flag     = zf_q;
  assign bus.carry_flag    = cf_q;
  assign bus.overflow_flag = vf_q;
endmodule
